mda_crtc_regs: RTL

- CPU-side I/O register block for the MDA adapter at ports 03B0h-03BFh, in the iClk (CPU) domain.
- Implements the MC6845 index/data register file subset, the mode control register (03B8h) and the status register (03BAh).
- Generates the cursor/attribute blink phases from frame counts.
- Feeds cursor, start-address and mode controls to video_mda; consumes its sync/blank outputs (25 MHz domain) through synchronisers.

---
 rtl/mda_crtc_regs_pkg.sv | 48 ++++
 rtl/mda_crtc_regs_if.sv | 20 ++
 rtl/mda_crtc_regs_cdc_sync.sv | 18 +
 rtl/mda_crtc_regs.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mda_crtc_regs_pkg.sv
// MDA CRTC register block: shared constants, port decode and reset values.
// Imported by the interface, synchroniser and top.
package mda_crtc_regs_pkg;

    typedef enum logic [2:0] {
        P_IDX,
        P_DATA,
        P_MODE,
        P_STAT,
        P_NONE
    } port_e;

    localparam logic [3:0] OFF_MODE = 4'h8;
    localparam logic [3:0] OFF_STAT = 4'hA;

    localparam logic [4:0] R_CUR_START = 5'd10;
    localparam logic [4:0] R_CUR_END   = 5'd11;
    localparam logic [4:0] R_START_HI  = 5'd12;
    localparam logic [4:0] R_START_LO  = 5'd13;
    localparam logic [4:0] R_CUR_HI    = 5'd14;
    localparam logic [4:0] R_CUR_LO    = 5'd15;
    localparam logic [4:0] R_MISC_CNT  = 5'd10;

    localparam logic [6:0] R10_RST = 7'h0B;
    localparam logic [4:0] R11_RST = 5'h0C;

    localparam logic [3:0] STAT_FIXED = 4'hF;
    localparam logic [7:0] RD_NONE    = 8'hFF;

    localparam int MODE_HIRES = 0;
    localparam int MODE_VIDEO = 3;
    localparam int MODE_BLINK = 5;

    // Offsets 0-7 alias the 6845 index/data pair on even/odd addresses.
    function automatic port_e port_decode(input logic [3:0] off);
        port_e p;
        p = P_NONE;
        unique case (1'b1)
            (!off[3] && !off[0]): p = P_IDX;
            (!off[3] && off[0]):  p = P_DATA;
            (off == OFF_MODE):    p = P_MODE;
            (off == OFF_STAT):    p = P_STAT;
            default:              p = P_NONE;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/mda_crtc_regs_if.sv
// CPU I/O bus for the MDA register block.
// master = CPU side, slave = register block.
interface mda_crtc_regs_if;
    logic [15:0] iAddr;
    logic [7:0]  iData;
    logic        iIoWr;
    logic        iIoRd;
    logic [7:0]  oData;
    logic        oDataValid;

    modport master (
        output iAddr, iData, iIoWr, iIoRd,
        input  oData, oDataValid
    );

    modport slave (
        input  iAddr, iData, iIoWr, iIoRd,
        output oData, oDataValid
    );
endinterface

// File: rtl/mda_crtc_regs_cdc_sync.sv
// Single-bit multi-flop synchroniser with asynchronous active-high reset.
module cdc_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);
    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) sync_q <= '0;
        else       sync_q <= {sync_q[STAGES-2:0], d_i};
    end

    assign q_o = sync_q[STAGES-1];
endmodule

// File: rtl/mda_crtc_regs.sv
// MDA CPU-side I/O registers: 6845 subset, mode and status ports,
// plus frame-counted cursor and attribute blink phases.
module mda_crtc_regs
    import mda_crtc_regs_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR    = 16'h03B0,
    parameter int          CUR_FAST_DIV = 16,
    parameter int          CUR_SLOW_DIV = 32,
    parameter int          SYNC_STAGES  = 2
) (
    input  logic           iClk,
    input  logic           iRst,
    mda_crtc_regs_if.slave bus,
    input  logic           iVgaHs,
    input  logic           iVgaVs,
    input  logic           iVgaBlank,
    output logic [13:0]    oStartAddr,
    output logic [13:0]    oCursorAddr,
    output logic [4:0]     oCursorStart,
    output logic [4:0]     oCursorEnd,
    output logic           oCursorVis,
    output logic           oAttrBlink,
    output logic           oVideoEn,
    output logic           oBlinkEn,
    output logic           oHiRes
);
    localparam int CW = $clog2(CUR_SLOW_DIV);
    localparam int FB = $clog2(CUR_FAST_DIV) - 1;
    localparam int SB = CW - 1;

    logic [4:0]    idx_q, idx_d;
    logic [7:0]    misc_unused_q [10];
    logic [7:0]    misc_unused_d [10];
    logic [6:0]    r10_q, r10_d;
    logic [4:0]    r11_q, r11_d;
    logic [5:0]    r12_q, r12_d;
    logic [7:0]    r13_q, r13_d;
    logic [5:0]    r14_q, r14_d;
    logic [7:0]    r15_q, r15_d;
    logic          hires_q, hires_d;
    logic          video_q, video_d;
    logic          blink_q, blink_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          vs_prev_q;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;

    logic          vs_s, hb_s, tick, hit, wr, rd;
    logic [7:0]    rdata;
    port_e         port;
    logic          unused_hs;

    assign unused_hs = iVgaHs;

    cdc_sync #(.STAGES(SYNC_STAGES)) u_sync_vs (
        .clk_i (iClk),
        .rst_i (iRst),
        .d_i   (iVgaVs),
        .q_o   (vs_s)
    );

    // Blanking during vsync is reported only through the vsync bit.
    cdc_sync #(.STAGES(SYNC_STAGES)) u_sync_hb (
        .clk_i (iClk),
        .rst_i (iRst),
        .d_i   (iVgaBlank & ~iVgaVs),
        .q_o   (hb_s)
    );

    assign tick = vs_s & ~vs_prev_q;
    assign hit  = bus.iAddr[15:4] == BASE_ADDR[15:4];
    assign port = port_decode(bus.iAddr[3:0]);
    assign wr   = hit & bus.iIoWr;
    assign rd   = hit & bus.iIoRd & ~bus.iIoWr;

    always_comb begin
        rdata = 8'h00;
        unique case (port)
            P_IDX:  rdata = 8'h00;
            P_DATA: begin
                case (idx_q)
                    R_START_HI: rdata = {2'b00, r12_q};
                    R_START_LO: rdata = r13_q;
                    R_CUR_HI:   rdata = {2'b00, r14_q};
                    R_CUR_LO:   rdata = r15_q;
                    default:    rdata = 8'h00;
                endcase
            end
            P_STAT: rdata = {STAT_FIXED, vs_s, 2'b00, hb_s};
            default: rdata = RD_NONE;
        endcase
    end

    always_comb begin
        idx_d         = idx_q;
        misc_unused_d = misc_unused_q;
        r10_d         = r10_q;
        r11_d         = r11_q;
        r12_d         = r12_q;
        r13_d         = r13_q;
        r14_d         = r14_q;
        r15_d         = r15_q;
        hires_d       = hires_q;
        video_d       = video_q;
        blink_d       = blink_q;
        if (wr) begin
            unique case (port)
                P_IDX:  idx_d = bus.iData[4:0];
                P_DATA: begin
                    if (idx_q < R_MISC_CNT) begin
                        misc_unused_d[idx_q[3:0]] = bus.iData;
                    end
                    case (idx_q)
                        R_CUR_START: r10_d = bus.iData[6:0];
                        R_CUR_END:   r11_d = bus.iData[4:0];
                        R_START_HI:  r12_d = bus.iData[5:0];
                        R_START_LO:  r13_d = bus.iData;
                        R_CUR_HI:    r14_d = bus.iData[5:0];
                        R_CUR_LO:    r15_d = bus.iData;
                        default:     ;
                    endcase
                end
                P_MODE: begin
                    hires_d = bus.iData[MODE_HIRES];
                    video_d = bus.iData[MODE_VIDEO];
                    blink_d = bus.iData[MODE_BLINK];
                end
                default: ;
            endcase
        end
        data_d  = rd ? rdata : 8'h00;
        valid_d = rd;
        cnt_d   = cnt_q + CW'(tick);
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            idx_q         <= '0;
            misc_unused_q <= '{default: '0};
            r10_q         <= R10_RST;
            r11_q         <= R11_RST;
            r12_q         <= '0;
            r13_q         <= '0;
            r14_q         <= '0;
            r15_q         <= '0;
            hires_q       <= 1'b0;
            video_q       <= 1'b0;
            blink_q       <= 1'b0;
            cnt_q         <= '0;
            vs_prev_q     <= 1'b0;
            data_q        <= 8'h00;
            valid_q       <= 1'b0;
        end else begin
            idx_q         <= idx_d;
            misc_unused_q <= misc_unused_d;
            r10_q         <= r10_d;
            r11_q         <= r11_d;
            r12_q         <= r12_d;
            r13_q         <= r13_d;
            r14_q         <= r14_d;
            r15_q         <= r15_d;
            hires_q       <= hires_d;
            video_q       <= video_d;
            blink_q       <= blink_d;
            cnt_q         <= cnt_d;
            vs_prev_q     <= vs_s;
            data_q        <= data_d;
            valid_q       <= valid_d;
        end
    end

    always_comb begin
        oCursorVis = 1'b1;
        unique case (r10_q[6:5])
            2'b00: oCursorVis = 1'b1;
            2'b01: oCursorVis = 1'b0;
            2'b10: oCursorVis = cnt_q[FB];
            2'b11: oCursorVis = cnt_q[SB];
            default: oCursorVis = 1'b1;
        endcase
    end

    assign oStartAddr     = {r12_q, r13_q};
    assign oCursorAddr    = {r14_q, r15_q};
    assign oCursorStart   = r10_q[4:0];
    assign oCursorEnd     = r11_q;
    assign oAttrBlink     = cnt_q[SB] & blink_q;
    assign oVideoEn       = video_q;
    assign oBlinkEn       = blink_q;
    assign oHiRes         = hires_q;
    assign bus.oData      = data_q;
    assign bus.oDataValid = valid_q;
endmodule
